// File: rtl/branch_predictor_param.sv
// rtl/branch_predictor_param.sv - parametrised bimodal/gshare branch predictor with tagged BTB and statistics
//
// Purpose: a table of 2^IDX_BITS saturating counters, optionally indexed by PC XOR global
// history (gshare). A direct-mapped tagged BTB can gate taken predictions. Resolved-branch
// and misprediction counters saturate. All state changes on the falling clock edge.
//
// Ports:
//   CLK, Reset         clock (state changes on negedge), async active-high reset
//   lk_pc              fetch PC for the combinational lookup
//   pred_taken         predicted direction
//   pred_target        BTB target for lk_pc (zero when the BTB is absent)
//   pred_idx           counter index used for this lookup, carried to EX
//   upd_valid          a resolved conditional branch is present
//   upd_pc             PC of the resolved branch (selects the BTB entry)
//   upd_idx            pred_idx snapshot taken at that branch's lookup
//   upd_taken          actual outcome
//   upd_target         actual taken target
//   upd_mispred        EX flagged a misprediction
//   stat_branches      saturating resolved-branch count
//   stat_mispred       saturating misprediction count
module branch_predictor_param #(
  parameter int ADDR_W    = 32,
  parameter int IDX_BITS  = 5,
  parameter int CTR_BITS  = 2,
  parameter int HIST_BITS = 0,
  parameter int BTB_EN    = 1,
  parameter int STAT_W    = 16
) (
  input  logic                CLK,
  input  logic                Reset,
  input  logic [ADDR_W-1:0]   lk_pc,
  output logic                pred_taken,
  output logic [ADDR_W-1:0]   pred_target,
  output logic [IDX_BITS-1:0] pred_idx,
  input  logic                upd_valid,
  input  logic [ADDR_W-1:0]   upd_pc,
  input  logic [IDX_BITS-1:0] upd_idx,
  input  logic                upd_taken,
  input  logic [ADDR_W-1:0]   upd_target,
  input  logic                upd_mispred,
  output logic [STAT_W-1:0]   stat_branches,
  output logic [STAT_W-1:0]   stat_mispred
);

  localparam int ENTRIES = 1 << IDX_BITS;
  localparam int TAG_W   = ADDR_W - IDX_BITS - 2;
  // History register keeps a minimum width of 1 so it can be declared in bimodal mode.
  localparam int HIST_W  = (HIST_BITS > 0) ? HIST_BITS : 1;

  // Weakly not-taken: MSB clear, all lower bits set (CTR_BITS=1 gives 0).
  localparam logic [CTR_BITS-1:0] CTR_INIT = CTR_BITS'((1 << (CTR_BITS - 1)) - 1);
  localparam logic [CTR_BITS-1:0] CTR_MAX  = '1;
  localparam logic [STAT_W-1:0]   STAT_MAX = '1;

  logic [CTR_BITS-1:0] ctr_q [ENTRIES];
  logic [CTR_BITS-1:0] ctr_d [ENTRIES];
  logic [HIST_W-1:0]   hist_q;
  logic [HIST_W-1:0]   hist_d;
  logic [STAT_W-1:0]   branches_q;
  logic [STAT_W-1:0]   branches_d;
  logic [STAT_W-1:0]   mispred_q;
  logic [STAT_W-1:0]   mispred_d;

  logic [IDX_BITS-1:0] lk_word;
  logic [IDX_BITS-1:0] hist_ext;
  logic                btb_hit;
  logic [ADDR_W-1:0]   btb_target;

  // PCs are word aligned, so the two LSBs never carry information.
  logic unused_lsbs;
  assign unused_lsbs = ^{lk_pc[1:0], upd_pc[1:0]};

  // ---------------------------------------------------------------------------
  // Lookup
  // ---------------------------------------------------------------------------
  assign lk_word  = lk_pc[IDX_BITS+1:2];
  // History occupies the low bits of the index; upper bits are XORed with zero.
  assign hist_ext = (HIST_BITS > 0) ? IDX_BITS'(hist_q) : '0;
  assign pred_idx = lk_word ^ hist_ext;

  assign pred_taken    = ctr_q[pred_idx][CTR_BITS-1] & btb_hit;
  assign pred_target   = btb_target;
  assign stat_branches = branches_q;
  assign stat_mispred  = mispred_q;

  // ---------------------------------------------------------------------------
  // Next-state: counters, history, statistics
  // ---------------------------------------------------------------------------
  // upd_idx is trusted as-is: recomputing it from upd_pc would use the
  // history at resolve time, not the history the prediction was made with.
  always_comb begin
    ctr_d = ctr_q;
    if (upd_valid) begin
      if (upd_taken) begin
        if (ctr_q[upd_idx] != CTR_MAX) begin
          ctr_d[upd_idx] = ctr_q[upd_idx] + 1'b1;
        end
      end else if (ctr_q[upd_idx] != '0) begin
        ctr_d[upd_idx] = ctr_q[upd_idx] - 1'b1;
      end
    end
  end

  // Non-speculative history: shifts only when a branch resolves, newest outcome in bit 0.
  always_comb begin
    hist_d = hist_q;
    if (upd_valid && (HIST_BITS > 0)) begin
      hist_d = HIST_W'({hist_q, upd_taken});
    end
  end

  always_comb begin
    branches_d = branches_q;
    mispred_d  = mispred_q;
    if (upd_valid) begin
      if (branches_q != STAT_MAX) begin
        branches_d = branches_q + 1'b1;
      end
      if (upd_mispred && (mispred_q != STAT_MAX)) begin
        mispred_d = mispred_q + 1'b1;
      end
    end
  end

  always_ff @(negedge CLK or posedge Reset) begin
    if (Reset) begin
      for (int i = 0; i < ENTRIES; i++) begin
        ctr_q[i] <= CTR_INIT;
      end
      hist_q     <= '0;
      branches_q <= '0;
      mispred_q  <= '0;
    end else begin
      ctr_q      <= ctr_d;
      hist_q     <= hist_d;
      branches_q <= branches_d;
      mispred_q  <= mispred_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Branch target buffer (direct mapped on the unhashed PC index)
  // ---------------------------------------------------------------------------
  generate
    if (BTB_EN != 0) begin : g_btb
      logic                valid_q [ENTRIES];
      logic [TAG_W-1:0]    tag_q   [ENTRIES];
      logic [ADDR_W-1:0]   tgt_q   [ENTRIES];
      logic [IDX_BITS-1:0] upd_bidx;
      logic                btb_write;

      assign upd_bidx  = upd_pc[IDX_BITS+1:2];
      // Only taken outcomes write; not-taken never invalidates an entry.
      assign btb_write = upd_valid & upd_taken;

      always_ff @(negedge CLK or posedge Reset) begin
        if (Reset) begin
          for (int i = 0; i < ENTRIES; i++) begin
            valid_q[i] <= 1'b0;
            tag_q[i]   <= '0;
            tgt_q[i]   <= '0;
          end
        end else if (btb_write) begin
          valid_q[upd_bidx] <= 1'b1;
          tag_q[upd_bidx]   <= upd_pc[ADDR_W-1:IDX_BITS+2];
          tgt_q[upd_bidx]   <= upd_target;
        end
      end

      assign btb_hit    = valid_q[lk_word] && (tag_q[lk_word] == lk_pc[ADDR_W-1:IDX_BITS+2]);
      assign btb_target = tgt_q[lk_word];
    end else begin : g_no_btb
      logic unused_btb_inputs;
      assign unused_btb_inputs = ^{lk_pc[ADDR_W-1:IDX_BITS+2], upd_pc[ADDR_W-1:2], upd_target};
      assign btb_hit    = 1'b1;
      assign btb_target = '0;
    end
  endgenerate

endmodule
